// File: rtl/button_event.sv
// Gesture classifier for a debounced push button: press/release edges,
// single click, double click and long press, plus a wrapping press counter.
module button_event #(
    parameter int unsigned c_LONG_LIMIT    = 25000000,
    parameter int unsigned c_DOUBLE_WINDOW = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch,
    output logic       o_Press,
    output logic       o_Release,
    output logic       o_Single,
    output logic       o_Double,
    output logic       o_Long,
    output logic [7:0] o_Presses
);

    localparam int unsigned c_COUNT_W = 25;
    localparam logic [c_COUNT_W-1:0] c_LONG_LAST   = c_COUNT_W'(c_LONG_LIMIT - 1);
    localparam logic [c_COUNT_W-1:0] c_DOUBLE_LAST = c_COUNT_W'(c_DOUBLE_WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2,
        WAIT2   = 2'd3
    } state_t;

    state_t                 r_State;
    state_t                 w_Next_State;
    logic [c_COUNT_W-1:0]   r_Count;
    logic [c_COUNT_W-1:0]   w_Next_Count;
    logic                   r_Second;
    logic                   w_Next_Second;
    logic                   r_Prev;
    logic                   w_Rise;
    logic                   w_Fall;
    logic                   w_Single;
    logic                   w_Double;
    logic                   w_Long;

    // Edge detection against the previous sampled level
    assign w_Rise = i_Switch & ~r_Prev;
    assign w_Fall = ~i_Switch & r_Prev;

    // State, counter and edge history registers; r_Prev tracks the switch
    // even in reset so a button held through reset is not seen as a press
    always_ff @(posedge i_Clk) begin
        r_Prev <= i_Switch;
        if (i_Rst) begin
            r_State  <= IDLE;
            r_Count  <= '0;
            r_Second <= 1'b0;
        end else begin
            r_State  <= w_Next_State;
            r_Count  <= w_Next_Count;
            r_Second <= w_Next_Second;
        end
    end

    // Next-state, counter and gesture pulse decode
    always_comb begin
        w_Next_State  = r_State;
        w_Next_Count  = r_Count;
        w_Next_Second = r_Second;
        w_Single      = 1'b0;
        w_Double      = 1'b0;
        w_Long        = 1'b0;
        unique case (r_State)
            IDLE: begin
                w_Next_Count = '0;
                if (w_Rise) begin
                    w_Next_State  = PRESSED;
                    w_Next_Second = 1'b0;
                end
            end
            PRESSED: begin
                // A release on the terminal cycle keeps the press short
                if (w_Fall) begin
                    w_Next_Count = '0;
                    w_Next_State = r_Second ? IDLE : WAIT2;
                end else if (r_Count == c_LONG_LAST) begin
                    w_Long       = 1'b1;
                    w_Next_Count = '0;
                    w_Next_State = LONG;
                end else begin
                    w_Next_Count = r_Count + c_COUNT_W'(1);
                end
            end
            LONG: begin
                w_Next_Count = '0;
                if (w_Fall) begin
                    w_Next_State = IDLE;
                end
            end
            WAIT2: begin
                // A second press on the terminal cycle still counts as a double
                if (w_Rise) begin
                    w_Double      = 1'b1;
                    w_Next_Count  = '0;
                    w_Next_Second = 1'b1;
                    w_Next_State  = PRESSED;
                end else if (r_Count == c_DOUBLE_LAST) begin
                    w_Single     = 1'b1;
                    w_Next_Count = '0;
                    w_Next_State = IDLE;
                end else begin
                    w_Next_Count = r_Count + c_COUNT_W'(1);
                end
            end
            default: begin
                w_Next_State = IDLE;
                w_Next_Count = '0;
            end
        endcase
    end

    // Registered event pulses and press counter
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Single  <= 1'b0;
            o_Double  <= 1'b0;
            o_Long    <= 1'b0;
            o_Presses <= 8'd0;
        end else begin
            o_Press   <= w_Rise;
            o_Release <= w_Fall;
            o_Single  <= w_Single;
            o_Double  <= w_Double;
            o_Long    <= w_Long;
            if (w_Rise) begin
                o_Presses <= o_Presses + 8'd1;
            end
        end
    end

endmodule
